fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter p_WIDTH, default 8: data bits per frame; equals the upstream FIFO data width.
REQ-002 SHALL have parameter p_CLKS_PER_BIT, default 868: i_clk cycles per serial bit; legal range is 2 and above.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_enable, input, 1: permits a new frame to start; has no effect on a frame already in progress.
REQ-006 SHALL have port i_fifo_empty, input, 1: FIFO empty flag (registered, may lag a pop by one cycle).
REQ-007 SHALL have port i_fifo_rd_data, input, p_WIDTH: FIFO head word, first-word-fall-through, valid while i_fifo_empty=0.
REQ-008 SHALL have port o_fifo_rd_en, output, 1: one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port o_tx, output, 1: serial line, idle high, registered.
REQ-010 SHALL have port o_busy, output, 1: high while a frame is being shifted out.
REQ-011 SHALL have port o_done, output, 1: one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 SHALL implement states IDLE, START, DATA, [PARITY], STOP, with IDLE->START->DATA->(PARITY)->STOP->IDLE.
REQ-013 SHALL, in IDLE at cycle T with i_enable=1 and i_fifo_empty=0, assert o_fifo_rd_en for cycle T only, capture i_fifo_rd_data into the shift register at T, and enter START at T+1.
REQ-014 SHALL keep o_fifo_rd_en low in every state other than IDLE, and low in IDLE whenever i_enable=0 or i_fifo_empty=1; exactly one pop per frame.
REQ-015 SHALL drive o_tx=0 for the p_CLKS_PER_BIT cycles T+1..T+p_CLKS_PER_BIT (START).
REQ-016 SHALL then shift the p_WIDTH data bits LSB first, each held for exactly p_CLKS_PER_BIT cycles, using a bit counter of width $clog2(p_WIDTH) that wraps to 0 on leaving DATA.
REQ-017 SHALL then drive o_tx=1 for p_CLKS_PER_BIT cycles (STOP), assert o_done on the final STOP cycle, and return to IDLE on the next cycle.
REQ-018 SHALL use a baud counter of width $clog2(p_CLKS_PER_BIT) that counts 0..p_CLKS_PER_BIT-1, reloads to 0 at each bit boundary, and never overflows.
REQ-019 SHALL hold o_busy=1 from START entry through the final STOP cycle inclusive, and 0 in IDLE.
REQ-020 SHALL spend at least one IDLE cycle between consecutive frames, so the earliest back-to-back start bit begins 1 cycle after the previous stop bit ends; this also absorbs the one-cycle empty-flag lag.
REQ-021 SHALL ignore changes on i_fifo_rd_data and i_fifo_empty during a frame; the transmitted word is the one captured at T.
REQ-022 SHALL, when i_enable falls mid-frame, finish the current frame and then remain in IDLE with o_tx=1.

Reset
REQ-023 SHALL, on i_rst=1 at any clock edge, including mid-frame, enter IDLE and set o_tx=1, o_busy=0, o_done=0, o_fifo_rd_en=0, counters=0, and shift register=0; the partial frame is abandoned and not retransmitted.
REQ-024 SHALL give i_rst priority over every other input in the same cycle.

Configuration
REQ-025 SHALL, with macro FIFO_UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the p_WIDTH data bits) for p_CLKS_PER_BIT cycles; frame = 1+p_WIDTH+1+1 bits.
REQ-026 SHALL, with FIFO_UART_TX_PARITY_EN undefined, omit the PARITY state and its logic entirely; frame = 1+p_WIDTH+1 bits and DATA goes directly to STOP.

Verification (p_WIDTH=8, p_CLKS_PER_BIT=4 unless noted)
REQ-027 SHALL verify single byte: FIFO holds 0xA5, i_enable=1 -> one rd_en pulse; o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_done pulses once at cycle 40 after the pop; o_busy high for exactly 40 cycles.
REQ-028 SHALL verify back-to-back: FIFO holds 0x00 then 0xFF -> two rd_en pulses 41 cycles apart; exactly 1 idle-high cycle between the first stop bit and the second start bit.
REQ-029 SHALL verify empty/disabled: i_fifo_empty=1 for 100 cycles, then data present with i_enable=0 -> o_fifo_rd_en never asserted, o_tx=1, o_busy=0 throughout.
REQ-030 SHALL verify enable drop mid-frame: i_enable falls during bit 3 of 0x3C -> the frame completes correctly, and no second pop occurs although the FIFO is non-empty.
REQ-031 SHALL verify reset mid-frame: i_rst pulsed during DATA bit 5 -> the next cycle has o_tx=1, o_busy=0; the next frame starts cleanly with a fresh pop.
REQ-032 SHALL verify parity (macro defined): 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame length 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: one pop per 8N1 frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
   parameter int p_WIDTH        = 8,
   parameter int p_CLKS_PER_BIT = 868
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_fifo_empty,
   input  logic [p_WIDTH-1:0] i_fifo_rd_data,
   output logic               o_fifo_rd_en,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_done,
   output logic [2:0]         o_dbg_state
);

   localparam int CW = (p_CLKS_PER_BIT > 1) ? $clog2(p_CLKS_PER_BIT) : 1;
   localparam int BW = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(p_CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_DONE = CW'(p_CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(p_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
`ifdef FIFO_UART_TX_PARITY_EN
      , S_PARITY = 3'd3
`endif
   } state_t;

   state_t             state;
   logic [CW-1:0]      baud;
   logic [BW-1:0]      bit_cnt;
   logic [p_WIDTH-1:0] shift;
`ifdef FIFO_UART_TX_PARITY_EN
   logic               parity_bit;
`endif

   // FIFO handshake: the head word is valid while i_fifo_empty=0; o_fifo_rd_en is
   // the pop strobe, high only in the single IDLE cycle in which that word is captured.
   assign o_fifo_rd_en = (state == S_IDLE) && i_enable && !i_fifo_empty && !i_rst;
   assign o_dbg_state  = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         o_tx    <= 1'b1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               baud    <= '0;
               bit_cnt <= '0;
               if (o_fifo_rd_en) begin
                  shift  <= i_fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                  parity_bit <= ^i_fifo_rd_data;
`endif
                  state  <= S_START;
                  o_tx   <= 1'b0;
                  o_busy <= 1'b1;
               end
            end
            S_START: begin
               if (baud == BAUD_LAST) begin
                  baud  <= '0;
                  state <= S_DATA;
                  o_tx  <= shift[0];
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_DATA: begin
               if (baud == BAUD_LAST) begin
                  baud <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                     state <= S_PARITY;
                     o_tx  <= parity_bit;
`else
                     state <= S_STOP;
                     o_tx  <= 1'b1;
`endif
                  end else begin
                     // Shift so the next bit to send always sits at position 1.
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= {1'b0, shift[p_WIDTH-1:1]};
                     o_tx    <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud == BAUD_LAST) begin
                  baud  <= '0;
                  state <= S_STOP;
                  o_tx  <= 1'b1;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (baud == BAUD_LAST) begin
                  baud   <= '0;
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  baud <= baud + 1'b1;
                  // Registered, so raise it one cycle early to land on the last stop cycle.
                  if (baud == BAUD_DONE) o_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: table of frames plus reset, enable-drop and back-to-back sequences.
module tb_fifo_uart_tx;
   localparam int W   = 8;
   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_rd_data = '0;
   logic         fifo_rd_en;
   logic         tx;
   logic         busy;
   logic         done;
   logic [2:0]   dbg_state;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic [8:0] seq;
      logic       par;
   } vec_t;
   vec_t vecs[8];

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.p_WIDTH(W), .p_CLKS_PER_BIT(CPB)) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable),
      .i_fifo_empty(fifo_empty), .i_fifo_rd_data(fifo_rd_data),
      .o_fifo_rd_en(fifo_rd_en), .o_tx(tx), .o_busy(busy), .o_done(done),
      .o_dbg_state(dbg_state)
   );

   // FIFO model: pops on the strobe, then presents the new head; garbage data while empty.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         pops++;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      #2;
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = (fifo_q.size() == 0) ? W'($urandom_range(0, 255)) : fifo_q[0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input bit send);
      fifo_q.push_back(d);
      if (send) exp_q.push_back(d);
   endtask

   task automatic wait_pop(input string name, output int t);
      t = -1;
      for (int n = 0; n < 8; n++) begin
         cyc();
         if (fifo_rd_en) begin
            t = cyc_n;
            break;
         end
      end
      chk({name, " pop_seen"}, (t >= 0), 1);
   endtask

   task automatic idle_chk(input string name, input int n, input logic exp_rd);
      for (int i = 0; i < n; i++) begin
         cyc();
         chk({name, " tx"}, tx, 1'b1);
         chk({name, " busy"}, busy, 1'b0);
         chk({name, " done"}, done, 1'b0);
         chk({name, " rd_en"}, fifo_rd_en, exp_rd);
      end
   endtask

   task automatic check_frame(input string name, input logic [8:0] seq, input logic par,
                              input int drop_at);
      logic [7:0] rx;
      logic [7:0] ew;
      logic       eb;
      int         idx;
      rx = '0;
      for (int c = 1; c <= FL; c++) begin
         idx = (c - 1) / CPB;
         cyc();
         if (idx < 9) eb = seq[8 - idx];
         else if (idx == 9 && NB == 11) eb = par;
         else eb = 1'b1;
         chk({name, " tx"}, tx, eb);
         chk({name, " busy"}, busy, 1'b1);
         chk({name, " done"}, done, (c == FL));
         chk({name, " rd_en"}, fifo_rd_en, 1'b0);
         if (idx >= 1 && idx <= 8 && ((c - 1) % CPB) == CPB / 2) rx[idx-1] = tx;
         if (c == drop_at) begin
            drv();
            enable = 1'b0;
         end
      end
      ew = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk({name, " word"}, rx, ew);
   endtask

   initial begin
      int t1, t2, p0;
      vecs[0] = '{8'hA5, 9'b010100101, 1'b0};
      vecs[1] = '{8'h07, 9'b011100000, 1'b1};
      vecs[2] = '{8'h3C, 9'b000111100, 1'b0};
      vecs[3] = '{8'h00, 9'b000000000, 1'b0};
      vecs[4] = '{8'hFF, 9'b011111111, 1'b0};
      vecs[5] = '{8'h5A, 9'b001011010, 1'b0};
      vecs[6] = '{8'h81, 9'b010000001, 1'b0};
      vecs[7] = '{8'h01, 9'b010000000, 1'b1};

      rst = 1'b1;
      enable = 1'b0;
      repeat (3) cyc();
      chk("reset tx", tx, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset rd_en", fifo_rd_en, 1'b0);
      drv();
      rst = 1'b0;

      // Empty FIFO with enable high, then data present with enable low.
      enable = 1'b1;
      idle_chk("empty", 100, 1'b0);
      drv();
      enable = 1'b0;
      push(8'h55, 1'b0);
      idle_chk("disabled", 20, 1'b0);
      chk("disabled pops", pops, 0);
      drv();
      fifo_q.delete();

      // Single byte 0xA5.
      drv();
      enable = 1'b1;
      push(8'hA5, 1'b1);
      wait_pop("single", t1);
      check_frame("single", vecs[0].seq, vecs[0].par, 0);
      idle_chk("single after", 3, 1'b0);
      chk("single pops", pops, 1);

      // Table of frames, one at a time.
      for (int i = 0; i < 8; i++) begin
         drv();
         push(vecs[i].data, 1'b1);
         wait_pop($sformatf("vec%0d", i), t1);
         check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].par, 0);
         idle_chk($sformatf("vec%0d idle", i), 1, 1'b0);
      end

      // Back-to-back 0x00 then 0xFF: exactly one idle cycle between frames.
      drv();
      push(8'h00, 1'b1);
      push(8'hFF, 1'b1);
      wait_pop("b2b first", t1);
      check_frame("b2b first", vecs[3].seq, vecs[3].par, 0);
      cyc();
      chk("b2b gap rd_en", fifo_rd_en, 1'b1);
      chk("b2b gap tx", tx, 1'b1);
      chk("b2b gap busy", busy, 1'b0);
      t2 = cyc_n;
      chk("b2b pop spacing", t2 - t1, FL + 1);
      check_frame("b2b second", vecs[4].seq, vecs[4].par, 0);
      idle_chk("b2b after", 2, 1'b0);

      // Enable drops during data bit 3 of 0x3C; a second word stays queued.
      p0 = pops;
      drv();
      push(8'h3C, 1'b1);
      push(8'h99, 1'b0);
      wait_pop("drop", t1);
      check_frame("drop", vecs[2].seq, vecs[2].par, 4 * CPB + 2);
      idle_chk("drop after", 20, 1'b0);
      chk("drop pops", pops - p0, 1);

      // Reset during data bit 5, then a fresh frame.
      drv();
      fifo_q.delete();
      enable = 1'b1;
      push(8'h5A, 1'b0);
      wait_pop("rstmid", t1);
      for (int c = 1; c <= 6 * CPB + 1; c++) cyc();
      drv();
      rst = 1'b1;
      cyc();
      cyc();
      chk("rstmid tx", tx, 1'b1);
      chk("rstmid busy", busy, 1'b0);
      chk("rstmid done", done, 1'b0);
      drv();
      p0 = pops;
      push(8'h81, 1'b1);
      cyc();
      chk("rst priority rd_en", fifo_rd_en, 1'b0);
      drv();
      rst = 1'b0;
      wait_pop("after rst", t1);
      check_frame("after rst", vecs[6].seq, vecs[6].par, 0);
      idle_chk("after rst idle", 2, 1'b0);
      chk("after rst pops", pops - p0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
